// File: rtl/axi_s_chk_data_pkg.sv
// Shared types and constants for the AXI-Stream pattern checker.
// Also used by the frame generator for its LFSR seed and taps.
package axi_s_chk_data_pkg;

  localparam int FRAME_CNT_W = 32;
  localparam int ERR_CNT_W   = 16;

  localparam logic [3:0]  KEEP_ALL  = 4'hF;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Fibonacci form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    S_HUNT,
    S_SYNC,
    S_CHECK
  } state_e;

  function automatic logic [31:0] keep_mask(
    input logic [3:0] k
  );
    return {{8{k[3]}}, {8{k[2]}},
            {8{k[1]}}, {8{k[0]}}};
  endfunction

endpackage

// File: rtl/axi_s_chk_data_lfsr16.sv
// 16-bit Fibonacci LFSR, advances when enabled.
// Shared with the generator for randomised valid.
module lfsr16
  import axi_s_chk_data_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LFSR_SEED;
    end else if (i_en) begin
      state_q <= {^(state_q & LFSR_TAPS),
                  state_q[15:1]};
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/axi_s_chk_data.sv
// AXI-Stream incrementing-word checker with frame/error
// counters, lock flag and optional LFSR ready throttling.
module axi_s_chk_data
  import axi_s_chk_data_pkg::*;
#(
  parameter logic [3:0] P_KEEP        = 4'b1111,
  parameter int         P_FRAME_LEN   = 16,
  parameter int         P_LOCK_FRAMES = 4,
  parameter int         P_READY_MODE  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_axi_s_data,
  input  logic [3:0]             i_axi_s_keep,
  input  logic                   i_axi_s_last,
  input  logic                   i_axi_s_valid,
  output logic                   o_axi_s_ready,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic [ERR_CNT_W-1:0]   o_err_cnt,
  output logic                   o_err_pulse,
  output logic                   o_err_sticky,
  output logic                   o_locked
);

  localparam int IW = $clog2(P_FRAME_LEN);
  localparam int RW = $clog2(P_LOCK_FRAMES + 1);
  localparam logic [IW-1:0] IDX_MAX =
    IW'(P_FRAME_LEN - 1);
  localparam logic [RW-1:0] RUN_MAX =
    RW'(P_LOCK_FRAMES);

  state_e                 state_q, state_d;
  logic [31:0]            exp_q;
  logic [IW-1:0]          idx_q;
  logic                   bad_q;
  logic [RW-1:0]          run_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   pulse_q;
  logic                   sticky_q;
  logic                   locked_q;
  logic                   rdy_en_q;
  logic [15:0]            lfsr;
  logic                   unused_lfsr;

  lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (1'b1),
    .o_state (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:1];

  assign o_axi_s_ready = rdy_en_q &
    ((P_READY_MODE == 0) | lfsr[0]);

  logic          xfer, active, in_sync, at_max;
  logic [IW-1:0] cur_idx;
  logic [31:0]   mask;
  logic          data_bad, keep_bad, len_bad;
  logic          frame_bad;

  assign xfer    = i_axi_s_valid & o_axi_s_ready;
  assign active  = xfer & (state_q != S_HUNT);
  assign in_sync = (state_q == S_SYNC);
  // The seeding beat is always index 0 of its frame
  assign cur_idx = in_sync ? '0 : idx_q;
  assign at_max  = (cur_idx == IDX_MAX);
  assign mask    = i_axi_s_last ?
    keep_mask(P_KEEP) : '1;
  assign data_bad = !in_sync &&
    |((i_axi_s_data ^ exp_q) & mask);
  assign keep_bad = i_axi_s_keep !=
    (i_axi_s_last ? P_KEEP : KEEP_ALL);
  assign len_bad  = i_axi_s_last ? !at_max : at_max;
  assign frame_bad = bad_q | data_bad |
    keep_bad | len_bad;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HUNT:  if (xfer && i_axi_s_last)
                 state_d = S_SYNC;
      S_SYNC:  if (xfer) state_d = S_CHECK;
      S_CHECK: state_d = S_CHECK;
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_HUNT;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q       <= '0;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      run_q       <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      pulse_q     <= 1'b0;
      sticky_q    <= 1'b0;
      locked_q    <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      pulse_q  <= 1'b0;
      if (active) begin
        // Reseed on mismatch so one bad word costs one frame
        exp_q <= (in_sync | data_bad) ?
          i_axi_s_data + 32'd1 : exp_q + 32'd1;
        if (i_axi_s_last) begin
          idx_q       <= '0;
          bad_q       <= 1'b0;
          frame_cnt_q <= frame_cnt_q +
            FRAME_CNT_W'(1);
          if (frame_bad) begin
            if (err_cnt_q != '1)
              err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            pulse_q  <= 1'b1;
            sticky_q <= 1'b1;
            run_q    <= '0;
            locked_q <= 1'b0;
          end else begin
            if (run_q != RUN_MAX)
              run_q <= run_q + RW'(1);
            if (run_q >= RUN_MAX - RW'(1))
              locked_q <= 1'b1;
          end
        end else begin
          idx_q <= at_max ? cur_idx : cur_idx + IW'(1);
          bad_q <= frame_bad;
        end
      end
    end
  end

  assign o_frame_cnt  = frame_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_err_pulse  = pulse_q;
  assign o_err_sticky = sticky_q;
  assign o_locked     = locked_q;

endmodule

// File: tb/tb_axi_s_chk_data.sv
// Scoreboard bench for axi_s_chk_data: instance a uses defaults,
// instance b uses P_KEEP=4'b1000 with LFSR-throttled ready.
module tb_axi_s_chk_data;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d_a = '0, d_b = '0;
  logic [3:0]  k_a = '0, k_b = '0;
  logic        l_a = 0, l_b = 0, v_a = 0, v_b = 0;
  logic        r_a, r_b, p_a, p_b, s_a, s_b;
  logic        lk_a, lk_b;
  logic [31:0] fc_a, fc_b;
  logic [15:0] ec_a, ec_b;

  axi_s_chk_data dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_s_data(d_a), .i_axi_s_keep(k_a),
    .i_axi_s_last(l_a), .i_axi_s_valid(v_a),
    .o_axi_s_ready(r_a), .o_frame_cnt(fc_a),
    .o_err_cnt(ec_a), .o_err_pulse(p_a),
    .o_err_sticky(s_a), .o_locked(lk_a)
  );

  axi_s_chk_data #(
    .P_KEEP(4'b1000), .P_READY_MODE(1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_s_data(d_b), .i_axi_s_keep(k_b),
    .i_axi_s_last(l_b), .i_axi_s_valid(v_b),
    .o_axi_s_ready(r_b), .o_frame_cnt(fc_b),
    .o_err_cnt(ec_b), .o_err_pulse(p_b),
    .o_err_sticky(s_b), .o_locked(lk_b)
  );

  typedef struct packed {
    logic bad;
    logic locked;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  exp_t        ea, eb;
  int          checks = 0, errors = 0;
  int          run_a = 0, run_b = 0;
  logic [31:0] w_a, w_b;
  logic [31:0] pfa = '0, pfb = '0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic beat(input bit sel,
                      input logic [31:0] d,
                      input logic [3:0] k,
                      input logic l);
    int   n;
    logic rdy;
    n = 0;
    if (sel) begin d_b = d; k_b = k; l_b = l; v_b = 1; end
    else     begin d_a = d; k_a = k; l_a = l; v_a = 1; end
    do begin
      rdy = sel ? r_b : r_a;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 500);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL beat_timeout: sel=%0d got no ready, required ready within 500 cycles", sel);
    end
    if (sel) v_b = 0; else v_a = 0;
  endtask

  task automatic push(input bit sel, input bit bad);
    exp_t e;
    int   r;
    r = sel ? run_b : run_a;
    if (bad) r = 0;
    else if (r < 4) r++;
    e.bad = bad;
    e.locked = (r == 4);
    if (sel) begin run_b = r; q_b.push_back(e); end
    else     begin run_a = r; q_a.push_back(e); end
  endtask

  task automatic frame(input bit sel, input int len,
                       input logic [3:0] kl,
                       input int bi,
                       input logic [31:0] bv,
                       input bit counted,
                       input bit bad);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = sel ? w_b : w_a;
      beat(sel, (i == bi) ? bv : w,
           (i == len - 1) ? kl : 4'hF, i == len - 1);
      if (sel) w_b++; else w_a++;
    end
    if (counted) push(sel, bad);
  endtask

  task automatic do_reset();
    rst_n = 0;
    run_a = 0;
    run_b = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_ready"},  r_a,  0);
    chk({tag, "_fcnt"},   fc_a, 0);
    chk({tag, "_ecnt"},   ec_a, 0);
    chk({tag, "_pulse"},  p_a,  0);
    chk({tag, "_sticky"}, s_a,  0);
    chk({tag, "_locked"}, lk_a, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) pfa = '0;
    else begin
      if (fc_a != pfa) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL close_a: got frame_cnt=%0d, required no close", fc_a);
        end else begin
          ea = q_a.pop_front();
          chk("pulse_a", p_a, ea.bad);
          chk("locked_a", lk_a, ea.locked);
          chk("fstep_a", fc_a, pfa + 1);
        end
      end else if (p_a) begin
        checks++; errors++;
        $display("FAIL spur_pulse_a: got 1 required 0");
      end
      pfa = fc_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pfb = '0;
    else begin
      if (fc_b != pfb) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL close_b: got frame_cnt=%0d, required no close", fc_b);
        end else begin
          eb = q_b.pop_front();
          chk("pulse_b", p_b, eb.bad);
          chk("locked_b", lk_b, eb.locked);
          chk("fstep_b", fc_b, pfb + 1);
        end
      end else if (p_b) begin
        checks++; errors++;
        $display("FAIL spur_pulse_b: got 1 required 0");
      end
      pfb = fc_b;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero_a("rst");
    rst_n = 1;

    // Partial frame at release, then 9 good frames
    w_a = 32'd6;
    frame(0, 10, 4'hF, -1, 0, 0, 0);
    for (int f = 0; f < 9; f++)
      frame(0, 16, 4'hF, -1, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("p1_fcnt", fc_a, 9);
    chk("p1_ecnt", ec_a, 0);
    chk("p1_locked", lk_a, 1);
    chk("p1_sticky", s_a, 0);

    // Lock, corrupt word 0x25, relock; words wrap
    do_reset();
    w_a = 32'hFFFF_FFD0;
    frame(0, 16, 4'hF, -1, 0, 0, 0);
    for (int f = 0; f < 9; f++)
      frame(0, 16, 4'hF, (f == 4) ? 5 : -1,
            32'hDEAD_0000, 1, f == 4);
    repeat (3) @(posedge clk); #1;
    chk("p2_fcnt", fc_a, 9);
    chk("p2_ecnt", ec_a, 1);
    chk("p2_sticky", s_a, 1);
    chk("p2_locked", lk_a, 1);

    // Early end then late end, then good frames
    frame(0, 10, 4'hF, -1, 0, 1, 1);
    frame(0, 20, 4'hF, -1, 0, 1, 1);
    for (int f = 0; f < 4; f++)
      frame(0, 16, 4'hF, -1, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("p3_fcnt", fc_a, 15);
    chk("p3_ecnt", ec_a, 3);
    chk("p3_locked", lk_a, 1);

    // Reset mid-frame, outputs clear without a clock
    for (int i = 0; i < 5; i++) begin
      beat(0, w_a, 4'hF, 0);
      w_a++;
    end
    rst_n = 0;
    run_a = 0;
    #1;
    chk_zero_a("arst");
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 5; i < 16; i++) begin
      beat(0, w_a, 4'hF, i == 15);
      w_a++;
    end
    frame(0, 16, 4'hF, -1, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("p4_fcnt", fc_a, 1);
    chk("p4_ecnt", ec_a, 0);
    chk("p4_sticky", s_a, 0);

    // Throttled ready, masked last beat, bad keep
    do_reset();
    w_b = 32'h2EFF_FFD1;
    frame(1, 16, 4'b1000, -1, 0, 0, 0);
    for (int f = 0; f < 100; f++)
      frame(1, 16, 4'b1000, (f == 1) ? 15 : -1,
            32'h2FAA_AAAA, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("p5_fcnt", fc_b, 100);
    chk("p5_ecnt", ec_b, 0);
    chk("p5_locked", lk_b, 1);
    frame(1, 16, 4'b1100, -1, 0, 1, 1);
    frame(1, 16, 4'b1000, -1, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    chk("p6_fcnt", fc_b, 102);
    chk("p6_ecnt", ec_b, 1);
    chk("p6_sticky", s_b, 1);
    chk("p6_locked", lk_b, 0);

    repeat (5) @(posedge clk); #1;
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
